core_dmem_resp: RTL

Data-memory responder at the far end of the MEM-stage load/store interface. Accepts one request at a time: address from the ALU result, store data from rs2, plus size and signedness. Performs byte-lane-masked doubleword writes or aligned reads with sign/zero extension into a local synchronous array. Returns each result through a valid/ready response channel to the MEM stage, one cycle after acceptance.

---
 rtl/core_dmem_resp_pkg.sv | 36 +++
 rtl/core_dmem_ld_align.sv | 43 ++++
 rtl/core_dmem_resp.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/core_dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem_resp_pkg
// Purpose  : Shared definitions for the data-memory responder: operand width,
//            access-size encodings, responder state encodings and the
//            byte-enable helper used by the store path.
// Revision : 1.0  initial release
// ============================================================================
package core_dmem_resp_pkg;

    localparam int OPERAND_WIDTH = 64;

    // Access size encodings carried on req_size
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_D = 2'b11;

    // Responder state encodings
    localparam logic [0:0] DMEM_IDLE = 1'b0;
    localparam logic [0:0] DMEM_RESP = 1'b1;

    // Byte-enable pattern for an access of the given size starting at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            MEM_SIZE_B: mask = 8'h01;
            MEM_SIZE_H: mask = 8'h03;
            MEM_SIZE_W: mask = 8'h0F;
            default:    mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage : core_dmem_resp_pkg
`default_nettype wire

// File: rtl/core_dmem_ld_align.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem_ld_align
// Purpose  : Combinational load aligner. Shifts the raw doubleword right by
//            the byte lane, truncates to the access size and sign- or
//            zero-extends the result. Doubleword loads pass through unchanged
//            apart from the lane shift.
// Ports    : i_raw_word    raw 64-bit doubleword read from the array
//            i_lane        byte offset within the doubleword
//            i_size        access size (MEM_SIZE_B/H/W/D)
//            i_is_unsigned 1 = zero-extend, 0 = sign-extend
//            o_result      extended load result
// Revision : 1.0  initial release
// ============================================================================
module core_dmem_ld_align
    import core_dmem_resp_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] i_raw_word,
    input  logic [2:0]               i_lane,
    input  logic [1:0]               i_size,
    input  logic                     i_is_unsigned,
    output logic [OPERAND_WIDTH-1:0] o_result
);

    logic [OPERAND_WIDTH-1:0] w_shifted;

    assign w_shifted = i_raw_word >> {i_lane, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_size)
            MEM_SIZE_B: o_result = i_is_unsigned ? {56'd0, w_shifted[7:0]}
                                                 : {{56{w_shifted[7]}}, w_shifted[7:0]};
            MEM_SIZE_H: o_result = i_is_unsigned ? {48'd0, w_shifted[15:0]}
                                                 : {{48{w_shifted[15]}}, w_shifted[15:0]};
            MEM_SIZE_W: o_result = i_is_unsigned ? {32'd0, w_shifted[31:0]}
                                                 : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default:    o_result = w_shifted;
        endcase
    end

endmodule : core_dmem_ld_align
`default_nettype wire

// File: rtl/core_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : core_dmem_resp
// Purpose  : Data-memory responder for the MEM-stage load/store interface.
//            Accepts one request at a time, performs byte-masked stores or
//            aligned loads against a local synchronous array and returns the
//            result on a valid/ready response channel one cycle later.
//            Optional macro DMEM_ERR_CHECK_EN enables misalignment and range
//            fault detection; without it rsp_err is 0 and the index wraps.
// Ports    : clk, rst                     clock, synchronous active-high reset
//            req_valid/req_ready          request handshake
//            req_we, req_addr, req_wdata  store flag, byte address, store data
//            req_size, req_unsigned       access size, zero-extend select
//            rsp_valid/rsp_ready          response handshake
//            rsp_rdata, rsp_err           load result, access fault
// Revision : 1.0  initial release
// ============================================================================
module core_dmem_resp
    import core_dmem_resp_pkg::*;
#(
    parameter int          DEPTH     = 512,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [OPERAND_WIDTH-1:0] req_addr,
    input  logic [OPERAND_WIDTH-1:0] req_wdata,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OPERAND_WIDTH-1:0] rsp_rdata,
    output logic                     rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Handshake and state machine
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_req_fire;
    logic       w_rsp_fire;

    // Ready depends only on state and rsp_ready so a new request can be
    // accepted in the same cycle the outstanding response drains.
    assign req_ready  = (r_state == DMEM_IDLE) | rsp_ready;
    assign rsp_valid  = (r_state == DMEM_RESP);
    assign w_req_fire = req_valid & req_ready;
    assign w_rsp_fire = rsp_valid & rsp_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DMEM_IDLE: if (w_req_fire) w_state_nxt = DMEM_RESP;
            DMEM_RESP: if (w_rsp_fire && !w_req_fire) w_state_nxt = DMEM_IDLE;
            default:   w_state_nxt = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= DMEM_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [63:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic [2:0]       w_lane;
    logic             w_fault;

    assign w_off  = req_addr - BASE_ADDR;
    assign w_idx  = w_off[IDX_W+2:3];
    assign w_lane = w_off[2:0];

`ifdef DMEM_ERR_CHECK_EN
    logic w_misalign;
    logic w_out_of_range;

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            MEM_SIZE_H: w_misalign = w_off[0];
            MEM_SIZE_W: w_misalign = |w_off[1:0];
            MEM_SIZE_D: w_misalign = |w_off[2:0];
            default:    w_misalign = 1'b0;
        endcase
    end

    // Any set bit above the index field means off >= DEPTH*8
    assign w_out_of_range = |w_off[63:IDX_W+3];
    assign w_fault        = w_misalign | w_out_of_range;
`else
    // Upper offset bits are deliberately ignored: the index wraps.
    logic w_unused_off;
    assign w_unused_off = ^w_off[63:IDX_W+3];
    assign w_fault      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage: byte-masked writes, registered read
    // ------------------------------------------------------------------
    logic [OPERAND_WIDTH-1:0] r_mem [DEPTH];
    logic [OPERAND_WIDTH-1:0] r_rd_word;
    logic [7:0]               w_wmask;
    logic [OPERAND_WIDTH-1:0] w_wdata_sh;
    logic                     w_do_write;

    // Shifting an 8-bit mask drops any bytes that would land past lane 7.
    assign w_wmask    = size_mask(req_size) << w_lane;
    assign w_wdata_sh = req_wdata << {w_lane, 3'b000};
    assign w_do_write = !rst && w_req_fire && req_we && !w_fault;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    // Read port is not reset; its output is only observed when r_is_load.
    always_ff @(posedge clk) begin
        if (!rst && w_req_fire) r_rd_word <= r_mem[w_idx];
    end

    // ------------------------------------------------------------------
    // Response capture; held stable until the response fires
    // ------------------------------------------------------------------
    logic [2:0] r_lane;
    logic [1:0] r_size;
    logic       r_unsigned;
    logic       r_is_load;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= 3'd0;
            r_size     <= MEM_SIZE_B;
            r_unsigned <= 1'b0;
            r_is_load  <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_req_fire) begin
            r_lane     <= w_lane;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_is_load  <= !req_we && !w_fault;
            r_err      <= w_fault;
        end
    end

    logic [OPERAND_WIDTH-1:0] w_ld_result;

    core_dmem_ld_align u_ld_align (
        .i_raw_word    (r_rd_word),
        .i_lane        (r_lane),
        .i_size        (r_size),
        .i_is_unsigned (r_unsigned),
        .o_result      (w_ld_result)
    );

    assign rsp_rdata = (rsp_valid && r_is_load) ? w_ld_result : '0;
    assign rsp_err   = rsp_valid & r_err;

endmodule : core_dmem_resp
`default_nettype wire
